// File: rtl/load.sv
// load: buffer fill engine. Decodes a 128-bit load instruction, reads the
// requested byte range from DRAM through an AXI4 read master (bursts never
// cross a 4 KiB page, at most C_MAX_OUTSTANDING bursts in flight) and writes
// every returned 512-bit beat into the feature buffer picked by the group field.
module load #(
  parameter int LOAD_INST_LENGTH   = 128,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MAX_OUTSTANDING  = 4,
  parameter int C_AXI_BURST_LEN    = 64
) (
  input  logic                          aclk,
  input  logic                          areset,

  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,

  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,

  output logic                          load_write_buffer_1_A_wen,
  output logic [10:0]                   load_write_buffer_1_A_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_1_A_data,
  output logic                          load_write_buffer_1_B_wen,
  output logic [10:0]                   load_write_buffer_1_B_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_1_B_data,
  output logic                          load_write_buffer_2_A_wen,
  output logic [10:0]                   load_write_buffer_2_A_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_2_A_data,
  output logic                          load_write_buffer_2_B_wen,
  output logic [10:0]                   load_write_buffer_2_B_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_2_B_data,

  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [LOAD_INST_LENGTH-1:0]   ctrl_instruction
);

  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                          state;
  logic [15:0]                     total;
  logic [15:0]                     r_received;
  logic [15:0]                     ar_remaining;
  logic [OW-1:0]                   outstanding;
  logic [10:0]                     buf_addr;
  logic [5:0]                      group;
  logic [3:0]                      wen;
  logic [10:0]                     wr_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data;

  logic                            ar_hs;
  logic                            r_hs;
  logic                            r_last_hs;
  logic [OW-1:0]                   outstanding_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   start_sum;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   start_addr;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   next_addr;
  logic [16:0]                     size_sum;
  logic [15:0]                     start_total;
  logic [15:0]                     next_remaining;
  logic [6:0]                      start_beats;
  logic [6:0]                      next_beats;
  logic [8:0]                      issued;
  logic [3:0]                      sel;
  logic                            unused_bits;

  // Beats in the next burst: limited by what is left, the burst cap and the
  // distance to the next 4 KiB page (the address is always 64-byte aligned).
  function automatic logic [6:0] burst_beats(input logic [11:0] page_off,
                                             input logic [15:0] remaining);
    logic [12:0] to_page;
    logic [15:0] lim;
    to_page = (13'd4096 - {1'b0, page_off}) >> 6;
    lim = 16'(to_page);
    if (lim > 16'(C_AXI_BURST_LEN)) lim = 16'(C_AXI_BURST_LEN);
    if (remaining < lim) lim = remaining;
    return 7'(lim);
  endfunction

  assign ar_hs     = m_axi_arvalid & m_axi_arready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign r_last_hs = r_hs & m_axi_rlast;

  assign start_sum   = ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(ctrl_instruction[127:96]);
  assign start_addr  = {start_sum[C_M_AXI_ADDR_WIDTH-1:6], 6'd0};
  assign size_sum    = {1'b0, ctrl_instruction[95:80]} + 17'd63;
  assign start_total = {5'd0, size_sum[16:6]};
  assign start_beats = burst_beats(start_addr[11:0], start_total);

  assign issued         = {1'b0, m_axi_arlen} + 9'd1;
  assign next_addr      = m_axi_araddr + C_M_AXI_ADDR_WIDTH'({issued, 6'd0});
  assign next_remaining = ar_remaining - {7'd0, issued};
  assign next_beats     = burst_beats(next_addr[11:0], next_remaining);

  assign unused_bits = ^{ctrl_instruction[79:43], ctrl_instruction[31:6],
                         start_sum[5:0], size_sum[5:0]};

  // Bursts in flight after this cycle; a simultaneous issue and rlast cancel out.
  always_comb begin
    outstanding_next = outstanding;
    case ({ar_hs, r_last_hs})
      2'b10:   outstanding_next = outstanding + OW'(1);
      2'b01:   outstanding_next = outstanding - OW'(1);
      default: outstanding_next = outstanding;
    endcase
  end

  // One-hot group field to buffer select; anything else writes nowhere.
  always_comb begin
    sel = 4'b0000;
    case (group)
      6'b000010: sel = 4'b0001;
      6'b000100: sel = 4'b0010;
      6'b001000: sel = 4'b0100;
      6'b010000: sel = 4'b1000;
      default:   sel = 4'b0000;
    endcase
  end

  // Control FSM with the AR issuer and R sink running side by side in RUN.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= S_IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_rready  <= 1'b0;
      wen           <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      ap_done       <= 1'b0;
      total         <= '0;
      r_received    <= '0;
      ar_remaining  <= '0;
      outstanding   <= '0;
      buf_addr      <= '0;
      group         <= '0;
    end else begin
      wen     <= '0;
      ap_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            group        <= ctrl_instruction[5:0];
            total        <= start_total;
            ar_remaining <= start_total;
            r_received   <= '0;
            outstanding  <= '0;
            buf_addr     <= ctrl_instruction[42:32];
            if (start_total == 16'd0) begin
              state <= S_DONE;
            end else begin
              state         <= S_RUN;
              m_axi_araddr  <= start_addr;
              m_axi_arlen   <= {1'b0, start_beats} - 8'd1;
              m_axi_arvalid <= 1'b1;
              m_axi_rready  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          outstanding <= outstanding_next;
          if (ar_hs) begin
            m_axi_araddr  <= next_addr;
            m_axi_arlen   <= {1'b0, next_beats} - 8'd1;
            ar_remaining  <= next_remaining;
            m_axi_arvalid <= (next_remaining != 16'd0) &&
                             (outstanding_next < OW'(C_MAX_OUTSTANDING));
          end else if (!m_axi_arvalid && ar_remaining != 16'd0 &&
                       outstanding_next < OW'(C_MAX_OUTSTANDING)) begin
            m_axi_arvalid <= 1'b1;
          end
          if (r_hs) begin
            wen        <= sel;
            wr_addr    <= buf_addr;
            wr_data    <= m_axi_rdata;
            buf_addr   <= buf_addr + 11'd1;
            r_received <= r_received + 16'd1;
            if (r_received + 16'd1 == total) begin
              state        <= S_DONE;
              m_axi_rready <= 1'b0;
            end
          end
        end
        S_DONE: begin
          ap_done <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign load_write_buffer_1_A_wen  = wen[0];
  assign load_write_buffer_1_B_wen  = wen[1];
  assign load_write_buffer_2_A_wen  = wen[2];
  assign load_write_buffer_2_B_wen  = wen[3];
  assign load_write_buffer_1_A_addr = wr_addr;
  assign load_write_buffer_1_B_addr = wr_addr;
  assign load_write_buffer_2_A_addr = wr_addr;
  assign load_write_buffer_2_B_addr = wr_addr;
  assign load_write_buffer_1_A_data = wr_data;
  assign load_write_buffer_1_B_data = wr_data;
  assign load_write_buffer_2_A_data = wr_data;
  assign load_write_buffer_2_B_data = wr_data;

endmodule

// File: tb/tb_load.sv
// tb_load: scoreboard bench for the load engine. Expected ARs, buffer writes
// and completions are queued when a load is issued; a monitor pops and
// compares them whenever the DUT shows an AR handshake, a wen or ap_done.
module tb_load;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [3:0]   sel;
    logic [10:0]  line;
    logic [511:0] data;
  } wr_t;

  logic          aclk;
  logic          areset;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b1;
  logic [63:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [511:0]  m_axi_rdata;
  logic          m_axi_rlast;
  logic          wen_1a, wen_1b, wen_2a, wen_2b;
  logic [10:0]   addr_1a, addr_1b, addr_2a, addr_2b;
  logic [511:0]  data_1a, data_1b, data_2a, data_2b;
  logic          ap_start;
  logic          ap_done;
  logic [63:0]   ctrl_addr_offset;
  logic [127:0]  ctrl_instruction;

  int  total_checks = 0;
  int  bad_checks = 0;
  int  cycle = 0;
  int  ar_seen = 0;
  int  wr_seen = 0;
  int  done_seen = 0;
  int  first_rlast_cycle = -1;
  int  fifth_ar_cycle = -1;
  int  last_wen_cycle = -1;
  logic r_enable = 1'b1;
  logic ar_toggle = 1'b0;

  ar_t exp_ar[$];
  wr_t exp_wr[$];
  int  exp_done[$];
  ar_t rq[$];
  int  beat_idx = 0;

  load dut (
    .aclk(aclk), .areset(areset),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .load_write_buffer_1_A_wen(wen_1a), .load_write_buffer_1_A_addr(addr_1a), .load_write_buffer_1_A_data(data_1a),
    .load_write_buffer_1_B_wen(wen_1b), .load_write_buffer_1_B_addr(addr_1b), .load_write_buffer_1_B_data(data_1b),
    .load_write_buffer_2_A_wen(wen_2a), .load_write_buffer_2_A_addr(addr_2a), .load_write_buffer_2_A_data(data_2a),
    .load_write_buffer_2_B_wen(wen_2b), .load_write_buffer_2_B_addr(addr_2b), .load_write_buffer_2_B_data(data_2b),
    .ap_start(ap_start), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Free-running cycle count used to order events.
  always @(posedge aclk) cycle <= cycle + 1;

  // Optional AR back-pressure: toggle arready every cycle when enabled.
  always @(posedge aclk) begin
    #1;
    m_axi_arready = ar_toggle ? ~m_axi_arready : 1'b1;
  end

  // DRAM content: every beat carries a pattern derived from its byte address.
  function automatic logic [511:0] dataFor(input logic [63:0] a);
    return {8{a ^ 64'hC3C3_5A5A_0F0F_A5A5}};
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    total_checks++;
    bad_checks++;
    $display("[TB] FAIL %s: got an event expected none", name);
  endtask

  // AXI read slave: queues accepted bursts and returns beats in order.
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      rq.delete();
      beat_idx = 0;
      m_axi_rvalid <= 1'b0;
      m_axi_rlast  <= 1'b0;
      m_axi_rdata  <= '0;
    end else begin
      if (m_axi_arvalid && m_axi_arready) rq.push_back({m_axi_araddr, m_axi_arlen});
      if (m_axi_rvalid && m_axi_rready) begin
        if (m_axi_rlast) begin
          void'(rq.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
      if (r_enable && rq.size() > 0) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= dataFor(rq[0].addr + 64'(beat_idx) * 64'd64);
        m_axi_rlast  <= (beat_idx == int'(rq[0].len));
      end else begin
        m_axi_rvalid <= 1'b0;
        m_axi_rlast  <= 1'b0;
      end
    end
  end

  // Monitor: compare every observable DUT event with the scoreboard.
  logic        prev_arvalid = 1'b0;
  logic        prev_arready = 1'b0;
  logic [63:0] prev_araddr = '0;
  logic [7:0]  prev_arlen = '0;
  always @(negedge aclk) begin
    ar_t ea;
    wr_t ew;
    logic [3:0] wv;
    logic [10:0] a_sel;
    logic [511:0] d_sel;
    int nd;
    if (!areset) begin
      if (prev_arvalid && !prev_arready)
        checkOutput("ar_hold", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, prev_araddr, prev_arlen});
      if (m_axi_arvalid && m_axi_arready) begin
        ar_seen++;
        if (ar_seen == 5) fifth_ar_cycle = cycle;
        if (exp_ar.size() == 0) reportFail("ar_unexpected");
        else begin
          ea = exp_ar.pop_front();
          checkOutput("araddr", m_axi_araddr, ea.addr);
          checkOutput("arlen", m_axi_arlen, ea.len);
        end
      end
      if (m_axi_rvalid && m_axi_rready && m_axi_rlast && first_rlast_cycle < 0)
        first_rlast_cycle = cycle;
      wv = {wen_2b, wen_2a, wen_1b, wen_1a};
      if (wv != 4'b0000) begin
        wr_seen++;
        last_wen_cycle = cycle;
        if (exp_wr.size() == 0) reportFail("wr_unexpected");
        else begin
          ew = exp_wr.pop_front();
          case (ew.sel)
            4'b0010: begin a_sel = addr_1b; d_sel = data_1b; end
            4'b0100: begin a_sel = addr_2a; d_sel = data_2a; end
            4'b1000: begin a_sel = addr_2b; d_sel = data_2b; end
            default: begin a_sel = addr_1a; d_sel = data_1a; end
          endcase
          checkOutput("wen_sel", wv, ew.sel);
          checkOutput("wr_line", a_sel, ew.line);
          checkOutput("wr_data", d_sel, ew.data);
        end
      end
      if (ap_done) begin
        done_seen++;
        if (exp_done.size() == 0) reportFail("done_unexpected");
        else begin
          nd = exp_done.pop_front();
          checkOutput("done_wr_count", wr_seen, nd);
          if (last_wen_cycle >= 0) checkOutput("done_after_wen", cycle, last_wen_cycle + 1);
        end
      end
    end
    prev_arvalid = m_axi_arvalid && !areset;
    prev_arready = m_axi_arready;
    prev_araddr  = m_axi_araddr;
    prev_arlen   = m_axi_arlen;
  end

  task automatic startTest();
    ar_seen = 0;
    wr_seen = 0;
    first_rlast_cycle = -1;
    fifth_ar_cycle = -1;
    last_wen_cycle = -1;
  endtask

  task automatic pushAr(input logic [63:0] a, input logic [7:0] len);
    exp_ar.push_back({a, len});
  endtask

  // Issue one load; queue its expected buffer writes and completion.
  task automatic applyStimulus(input logic [31:0] a, input logic [63:0] off, input logic [15:0] size,
                               input logic [10:0] line, input logic [5:0] grp);
    logic [63:0] base;
    logic [3:0] sel;
    int beats;
    wr_t w;
    base = (off + {32'd0, a}) & ~64'h3F;
    beats = (int'(size) + 63) / 64;
    case (grp)
      6'b000010: sel = 4'b0001;
      6'b000100: sel = 4'b0010;
      6'b001000: sel = 4'b0100;
      6'b010000: sel = 4'b1000;
      default:   sel = 4'b0000;
    endcase
    for (int k = 0; k < beats; k++) begin
      if (sel != 4'b0000) begin
        w.sel = sel;
        w.line = line + 11'(k);
        w.data = dataFor(base + 64'(k) * 64'd64);
        exp_wr.push_back(w);
      end
    end
    exp_done.push_back(sel != 4'b0000 ? beats : 0);
    @(posedge aclk); #1;
    ctrl_instruction = '0;
    ctrl_instruction[127:96] = a;
    ctrl_instruction[95:80] = size;
    ctrl_instruction[42:32] = line;
    ctrl_instruction[5:0] = grp;
    ctrl_addr_offset = off;
    ap_start = 1'b1;
    checkOutput("arvalid_cycle0", m_axi_arvalid, 1'b0);
    @(posedge aclk); #1;
    ap_start = 1'b0;
    checkOutput("arvalid_cycle1", m_axi_arvalid, size != 16'd0);
    checkOutput("rready_cycle1", m_axi_rready, size != 16'd0);
  endtask

  task automatic finishTest();
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("ar_queue_empty", exp_ar.size(), 0);
    checkOutput("wr_queue_empty", exp_wr.size(), 0);
    checkOutput("done_queue_empty", exp_done.size(), 0);
    checkOutput("drained", rq.size(), 0);
  endtask

  task automatic waitDone(input int max_cycles);
    int n = 0;
    int d0 = done_seen;
    while (done_seen == d0 && n < max_cycles) begin
      @(posedge aclk);
      n++;
    end
    total_checks++;
    if (done_seen == d0) begin
      bad_checks++;
      $display("[TB] FAIL done_timeout: got no ap_done expected one within %0d cycles", max_cycles);
    end
    #1;
    checkOutput("done_one_cycle", ap_done, 1'b0);
    finishTest();
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_arvalid", m_axi_arvalid, 0);
    checkOutput("rst_araddr", m_axi_araddr, 0);
    checkOutput("rst_arlen", m_axi_arlen, 0);
    checkOutput("rst_rready", m_axi_rready, 0);
    checkOutput("rst_wen", {wen_1a, wen_1b, wen_2a, wen_2b}, 0);
    checkOutput("rst_addr", {addr_1a, addr_1b, addr_2a, addr_2b}, 0);
    checkOutput("rst_data_1a", data_1a, 0);
    checkOutput("rst_data_1b", data_1b, 0);
    checkOutput("rst_data_2a", data_2a, 0);
    checkOutput("rst_data_2b", data_2b, 0);
    checkOutput("rst_ap_done", ap_done, 0);
  endtask

  initial begin
    int n;
    int d0;
    areset = 1'b1;
    ap_start = 1'b0;
    ctrl_addr_offset = '0;
    ctrl_instruction = '0;
    repeat (3) @(posedge aclk);
    #1;
    checkResetOutputs();
    areset = 1'b0;

    $display("[TB] basic 1A load");
    startTest();
    pushAr(64'h11000, 8'd3);
    applyStimulus(32'h1000, 64'h10000, 16'd256, 11'd10, 6'b000010);
    waitDone(200);

    $display("[TB] burst split with ignored ap_start");
    startTest();
    pushAr(64'h0, 8'd63);
    pushAr(64'h1000, 8'd63);
    applyStimulus(32'h0, 64'h0, 16'd8192, 11'd0, 6'b000100);
    repeat (10) @(posedge aclk);
    #1;
    ctrl_instruction = '0;
    ctrl_instruction[127:96] = 32'h9000;
    ctrl_instruction[95:80] = 16'd64;
    ctrl_instruction[5:0] = 6'b010000;
    ap_start = 1'b1;
    @(posedge aclk); #1;
    ap_start = 1'b0;
    waitDone(500);

    $display("[TB] 4 KiB boundary with AR back-pressure");
    startTest();
    ar_toggle = 1'b1;
    pushAr(64'hFC0, 8'd0);
    pushAr(64'h1000, 8'd1);
    applyStimulus(32'hFC0, 64'h0, 16'd192, 11'd100, 6'b001000);
    waitDone(200);
    ar_toggle = 1'b0;

    $display("[TB] outstanding limit and line wrap");
    startTest();
    r_enable = 1'b0;
    for (int i = 0; i < 16; i++) pushAr(64'h40000 + 64'(i) * 64'h1000, 8'd63);
    applyStimulus(32'h0, 64'h40000, 16'hFFFF, 11'd2000, 6'b010000);
    repeat (18) @(posedge aclk);
    #1;
    checkOutput("ar_count_hold", ar_seen, 4);
    r_enable = 1'b1;
    waitDone(3000);
    checkOutput("fifth_ar_after_rlast", (first_rlast_cycle >= 0) && (fifth_ar_cycle > first_rlast_cycle), 1'b1);

    $display("[TB] size 100 with unaligned address and line wrap");
    startTest();
    pushAr(64'h2000, 8'd1);
    applyStimulus(32'h2010, 64'h0, 16'd100, 11'd2047, 6'b000010);
    waitDone(200);

    $display("[TB] size 0");
    startTest();
    applyStimulus(32'h8000, 64'h0, 16'd0, 11'd0, 6'b000010);
    checkOutput("size0_done_c1", ap_done, 1'b0);
    @(posedge aclk); #1;
    checkOutput("size0_done_c2", ap_done, 1'b1);
    @(posedge aclk); #1;
    checkOutput("size0_done_c3", ap_done, 1'b0);
    finishTest();

    $display("[TB] no group selected");
    startTest();
    pushAr(64'h5000, 8'd1);
    applyStimulus(32'h5000, 64'h0, 16'd128, 11'd0, 6'b000001);
    waitDone(200);
    checkOutput("nogroup_wen_count", wr_seen, 0);

    $display("[TB] reset mid-transfer");
    startTest();
    pushAr(64'h3000, 8'd15);
    applyStimulus(32'h3000, 64'h0, 16'd1024, 11'd300, 6'b000100);
    n = 0;
    while (wr_seen < 5 && n < 200) begin
      @(posedge aclk);
      n++;
    end
    checkOutput("beats_before_reset", wr_seen >= 5, 1'b1);
    #1;
    areset = 1'b1;
    exp_ar.delete();
    exp_wr.delete();
    exp_done.delete();
    #1;
    checkResetOutputs();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    d0 = done_seen;
    repeat (10) @(posedge aclk);
    #1;
    checkOutput("no_done_after_reset", done_seen, d0);
    checkOutput("idle_after_reset", m_axi_arvalid, 1'b0);

    $display("[TB] load after reset");
    startTest();
    pushAr(64'h7100, 8'd0);
    applyStimulus(32'h100, 64'h7000, 16'd64, 11'd5, 6'b001000);
    waitDone(200);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
